// File: rtl/ram_sample_scheduler_if.sv
// ============================================================================
// Module      : ram_sample_scheduler_if
// Description : Handshake and RAM-control bundle for ram_sample_scheduler.
//               Carries the AtoD sample handshake, the playback read
//               request/response, status (fill, overflow) and the RAM
//               address / WE / OE strobes. The bidirectional RAM data bus
//               stays a plain inout port on the scheduler.
//   master : the scheduler (drives ready, read data, status, RAM controls)
//   slave  : the surrounding logic (drives samples and read requests)
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface ram_sample_scheduler_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
);
  logic              sample_valid;
  logic [DATA_W-1:0] sample;
  logic              sample_ready;
  logic              rd_req;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W:0]   fill;
  logic              overflow;
  logic [ADDR_W-1:0] address;
  logic              WE;
  logic              OE;

  modport master (
    input  sample_valid, sample, rd_req,
    output sample_ready, rd_valid, rd_data, fill, overflow, address, WE, OE
  );

  modport slave (
    output sample_valid, sample, rd_req,
    input  sample_ready, rd_valid, rd_data, fill, overflow, address, WE, OE
  );
endinterface

`default_nettype wire

// File: rtl/ram_sample_scheduler.sv
// ============================================================================
// Module      : ram_sample_scheduler
// Description : Runs the shared RAM as a DEPTH-entry ring buffer between the
//               AtoD capture path (writes) and the playback path (reads).
//               One pending sample and one pending read are held; when both
//               are eligible the grant alternates. Every read is followed by
//               a turnaround cycle so the data bus is never driven right
//               after the RAM output enable drops.
// Ports       : clk    - system clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - handshake / status / RAM control (master modport)
//               data   - RAM data bus, driven only during a write cycle
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ram_sample_scheduler #(
  parameter int ADDR_W    = 3,
  parameter int DATA_W    = 16,
  parameter int OVERWRITE = 0
) (
  input  wire                       clk,
  input  wire                       rst_n,
  ram_sample_scheduler_if.master    bus,
  inout  wire [DATA_W-1:0]          data
);

  localparam logic [ADDR_W:0] c_DEPTH = {1'b1, {ADDR_W{1'b0}}};

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_WR   = 2'd1;
  localparam logic [1:0] c_RD   = 2'd2;
  localparam logic [1:0] c_TURN = 2'd3;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_fill;
  logic [DATA_W-1:0] r_hold;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_pend_valid;
  logic              r_rd_pend;
  logic              r_last_rd;     // 1 = last grant was a read
  logic              r_overflow;

  logic w_full;
  logic w_write_ok;
  logic w_read_ok;
  logic w_grant_wr;
  logic w_grant_rd;

  assign w_full     = (r_fill == c_DEPTH);
  assign w_write_ok = r_pend_valid & (~w_full | (OVERWRITE != 0));
  assign w_read_ok  = r_rd_pend & (r_fill != '0);

  // Round-robin only matters under contention; otherwise whoever is
  // eligible wins.
  always_comb begin
    w_grant_wr = 1'b0;
    w_grant_rd = 1'b0;
    if (r_state == c_IDLE) begin
      if (w_write_ok && w_read_ok) begin
        if (r_last_rd) w_grant_wr = 1'b1;
        else           w_grant_rd = 1'b1;
      end else if (w_write_ok) begin
        w_grant_wr = 1'b1;
      end else if (w_read_ok) begin
        w_grant_rd = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fill       <= '0;
      r_hold       <= '0;
      r_rd_data    <= '0;
      r_pend_valid <= 1'b0;
      r_rd_pend    <= 1'b0;
      r_last_rd    <= 1'b1;
      r_overflow   <= 1'b0;
    end else begin
      r_rd_pend <= bus.rd_req | (r_rd_pend & ~w_grant_rd);

      // Acceptance and the WR-end clear never coincide: the holding
      // register is full for the whole WR cycle.
      if (bus.sample_valid && !r_pend_valid) begin
        r_hold       <= bus.sample;
        r_pend_valid <= 1'b1;
      end

      case (r_state)
        c_IDLE: begin
          if (w_grant_wr) begin
            r_state   <= c_WR;
            r_last_rd <= 1'b0;
          end else if (w_grant_rd) begin
            r_state   <= c_RD;
            r_last_rd <= 1'b1;
          end
        end
        c_WR: begin
          r_wr_ptr     <= r_wr_ptr + 1'b1;
          r_pend_valid <= 1'b0;
          if (!w_full) begin
            r_fill <= r_fill + 1'b1;
          end else begin
            // Only reachable with OVERWRITE: the oldest entry is dropped.
            r_rd_ptr   <= r_rd_ptr + 1'b1;
            r_overflow <= 1'b1;
          end
          r_state <= c_IDLE;
        end
        c_RD: begin
          r_rd_data <= data;
          r_rd_ptr  <= r_rd_ptr + 1'b1;
          r_fill    <= r_fill - 1'b1;
          r_state   <= c_TURN;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // Strobes decode straight from the state register so the asynchronous
  // reset releases the bus without waiting for a clock edge.
  assign bus.WE       = (r_state == c_WR);
  assign bus.OE       = (r_state == c_RD);
  assign bus.address  = (r_state == c_WR) ? r_wr_ptr :
                        (r_state == c_RD) ? r_rd_ptr : '0;
  assign data         = (r_state == c_WR) ? r_hold : {DATA_W{1'bz}};
  assign bus.rd_valid = (r_state == c_TURN);
  assign bus.rd_data  = r_rd_data;
  assign bus.fill     = r_fill;
  assign bus.overflow = r_overflow;
  assign bus.sample_ready = ~r_pend_valid;

endmodule

`default_nettype wire
